// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and memory-wait control for a 5-stage in-order pipeline.
// Tracks shadow EX/MEM/WB records and arbitrates stall, bubble and freeze.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       id_read_reg1,
  input  logic       id_read_reg2,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_mem_write,
  input  logic       flush,
  input  logic       mem_ready,
  output logic       stall,
  output logic       ex_bubble,
  output logic       freeze,
  output logic [1:0] fwd1,
  output logic [1:0] fwd2,
  output logic       mem_req,
  output logic       mem_err
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned CMP_W = CNT_W + 1;

  typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, ERR = 2'd2} state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } stage_t;

  typedef struct packed {
    stage_t           st;
    logic             read1;
    logic             read2;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } ex_t;

  // WB only needs the fields that forwarding looks at.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } wb_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             flush_pend, flush_pend_d;
  ex_t              ex_q, ex_d, id_rec;
  stage_t           mem_q, mem_d;
  wb_t              wb_q, wb_d;

  logic             mem_req_i, freeze_i, stall_i, bubble_i;
  logic             flush_eff, hazard;
  logic             mem_fwd_ok, wb_fwd_ok;
  logic [1:0]       fwd1_i, fwd2_i;

  function automatic logic [1:0] fwd_pick(input logic rd_flag, input logic [REG_W-1:0] rs,
                                          input logic m_ok, input logic [REG_W-1:0] m_rd,
                                          input logic w_ok, input logic [REG_W-1:0] w_rd);
    logic [1:0] sel;
    sel = 2'd0;
    if (rd_flag && m_ok && (m_rd == rs))      sel = 2'd1;
    else if (rd_flag && w_ok && (w_rd == rs)) sel = 2'd2;
    return sel;
  endfunction

  always_comb begin
    id_rec              = '0;
    id_rec.st.valid     = 1'b1;
    id_rec.st.rd        = id_rd;
    id_rec.st.reg_write = id_reg_write;
    id_rec.st.mem_read  = id_mem_read;
    id_rec.st.mem_write = id_mem_write;
    id_rec.read1        = id_read_reg1;
    id_rec.read2        = id_read_reg2;
    id_rec.rs1          = id_rs1;
    id_rec.rs2          = id_rs2;
  end

  assign mem_req_i  = mem_q.valid && (mem_q.mem_read || mem_q.mem_write) && (state != ERR);
  assign freeze_i   = (state == ERR) || (mem_req_i && !mem_ready);
  assign flush_eff  = flush || flush_pend;
  assign hazard     = ex_q.st.valid && ex_q.st.mem_read && (ex_q.st.rd != '0) &&
                      ((id_read_reg1 && (id_rs1 == ex_q.st.rd)) ||
                       (id_read_reg2 && (id_rs2 == ex_q.st.rd)));
  assign mem_fwd_ok = mem_q.valid && mem_q.reg_write && (mem_q.rd != '0);
  assign wb_fwd_ok  = wb_q.valid && wb_q.reg_write && (wb_q.rd != '0);
  assign fwd1_i     = fwd_pick(ex_q.read1, ex_q.rs1, mem_fwd_ok, mem_q.rd, wb_fwd_ok, wb_q.rd);
  assign fwd2_i     = fwd_pick(ex_q.read2, ex_q.rs2, mem_fwd_ok, mem_q.rd, wb_fwd_ok, wb_q.rd);

  // Next-state: pipeline record advance plus the RUN/WAIT/ERR memory FSM.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    flush_pend_d = flush_pend;
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    stall_i      = 1'b0;
    bubble_i     = 1'b0;

    if (freeze_i) begin
      stall_i = 1'b1;
      if (flush) flush_pend_d = 1'b1;
    end else begin
      mem_d          = ex_q.st;
      wb_d.valid     = mem_q.valid;
      wb_d.rd        = mem_q.rd;
      wb_d.reg_write = mem_q.reg_write;
      flush_pend_d   = 1'b0;
      if (flush_eff) begin
        ex_d     = '0;
        bubble_i = 1'b1;
      end else if (hazard) begin
        ex_d     = '0;
        stall_i  = 1'b1;
        bubble_i = 1'b1;
      end else begin
        ex_d = id_valid ? id_rec : '0;
      end
    end

    // The RUN cycle that enters WAIT is the first frozen cycle, hence the +2.
    case (state)
      RUN: begin
        cnt_d = '0;
        if (freeze_i) state_d = WAIT;
      end
      WAIT: begin
        if (!freeze_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
          if ((CMP_W'(cnt) + CMP_W'(2)) >= CMP_W'(MEM_TIMEOUT)) state_d = ERR;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      flush_pend <= 1'b0;
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      flush_pend <= flush_pend_d;
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
    end
  end

  assign stall     = !rst && stall_i;
  assign ex_bubble = !rst && bubble_i;
  assign freeze    = !rst && freeze_i;
  assign mem_req   = !rst && mem_req_i;
  assign mem_err   = !rst && (state == ERR);
  assign fwd1      = rst ? 2'd0 : fwd1_i;
  assign fwd2      = rst ? 2'd0 : fwd2_i;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 255, number of consecutive frozen cycles after which a memory access is declared failed (range 1..1023).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_valid  in  1  decode stage holds a real instruction.
REQ-005 id_read_reg1, id_read_reg2  in  1 each  decoded instruction reads rs1 / rs2.
REQ-006 id_rs1, id_rs2, id_rd  in  5 each  decoded source and destination register addresses.
REQ-007 id_reg_write, id_mem_read, id_mem_write  in  1 each  decoded write-back, load and store flags.
REQ-008 flush  in  1  taken branch resolved in EX; discard the instruction in ID.
REQ-009 mem_ready  in  1  data memory completes the access requested this cycle.
REQ-010 stall  out  1  hold PC and the IF/ID and decode registers.
REQ-011 ex_bubble  out  1  load a no-op into EX instead of the decoded instruction.
REQ-012 freeze  out  1  hold the EX, MEM and WB pipeline registers.
REQ-013 fwd1, fwd2  out  2 each  EX operand source: 0 register file, 1 MEM-stage result, 2 WB-stage result.
REQ-014 mem_req  out  1  MEM stage requests a data-memory access.
REQ-015 mem_err  out  1  sticky memory-timeout error.

Function
REQ-016 The block SHALL keep shadow stage records for EX, MEM and WB: valid, rd, reg_write, mem_read, mem_write; EX also stores rs1, rs2 and their read flags.
REQ-017 States SHALL be RUN, WAIT and ERR.
REQ-018 mem_req SHALL be high whenever MEM is valid, MEM is a load or store, state is not ERR, and the access is not yet done.
REQ-019 freeze SHALL equal mem_req && !mem_ready in RUN/WAIT, and SHALL be 1 in ERR.
REQ-020 RUN->WAIT on freeze; WAIT->RUN on mem_ready; WAIT->ERR when the frozen-cycle counter reaches MEM_TIMEOUT; ERR exits only on rst.
REQ-021 The counter SHALL clear on entry to WAIT and on every unfrozen cycle.
REQ-022 While freeze=1, all shadow records SHALL hold, stall=1 and ex_bubble=0.
REQ-023 A load-use hazard SHALL be: EX valid, EX mem_read, EX rd!=0, and an ID source with read flag set equals EX rd.
REQ-024 On a load-use hazard with freeze=0 and no flush: stall=1 and ex_bubble=1 for exactly one cycle; EX<-bubble; MEM<-EX; WB<-MEM.
REQ-025 On flush with freeze=0: ID is discarded, ex_bubble=1 and stall=0; flush SHALL override a load-use hazard.
REQ-026 A flush arriving while freeze=1 SHALL be latched as pending and applied in the first unfrozen cycle.
REQ-027 In a normal advance: EX<-ID (invalid if !id_valid), MEM<-EX, WB<-MEM, stall=0, ex_bubble=0.
REQ-028 fwd1 SHALL be 1 if MEM is valid, MEM reg_write, MEM rd!=0 and MEM rd == EX rs1 (rs1 read flag set); otherwise 2 on the same match against WB; otherwise 0. fwd2 follows the same rule on rs2.
REQ-029 MEM-stage forwarding SHALL take priority over WB-stage forwarding.
REQ-030 Register x0 SHALL never cause a hazard or a forward.
REQ-031 mem_ready with mem_req=0 SHALL be ignored.
REQ-032 mem_ready asserted in the same cycle as mem_req SHALL complete the access with no freeze.

Reset
REQ-033 While rst=1: state RUN, all shadow valids 0, counter 0, pending flush 0, mem_err 0.
REQ-034 With rst=1 all outputs SHALL be 0 from the next edge, including when rst is asserted during WAIT or ERR.
REQ-035 The first instruction SHALL advance in the cycle after rst deasserts.

Verification
REQ-036 Load-use: lw x5 in EX, ID add x6,x5,x7 -> one cycle stall=1, ex_bubble=1; next cycle fwd1=2.
REQ-037 Back-to-back ALU: add x3 then sub x4,x3,x3 -> no stall; fwd1=fwd2=1; with WB also writing x3, still 1.
REQ-038 x0 destination: addi x0 then add x1,x0,x0 -> fwd1=fwd2=0, no stall.
REQ-039 Memory wait: lw in MEM, mem_ready low 3 cycles then high -> freeze=1 for 3 cycles, stages hold, advance on 4th.
REQ-040 Timeout: MEM_TIMEOUT=4, mem_ready never high -> ERR after 4 frozen cycles, mem_err=1 sticky; rst clears.
REQ-041 Flush during freeze: flush pulsed in frozen cycle 2 -> ID dropped (ex_bubble=1) in first unfrozen cycle; flush plus load-use together -> stall=0.
